reorder_frame_ctrl: RTL and testbench

REORDER_FRAME_CTRL -- requirements
Module: reorder_frame_ctrl

---
 rtl/reorder_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_reorder_frame_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_frame_ctrl.sv
// Ping-pong frame controller for the bit-reversal reorder buffer (two 512-point shift-register banks).
// Latency: shift_en/beat_idx one cycle after beat accept; frame valid two cycles after its last beat.
// Backpressure: in_ready drops while the write bank is FULL/READY; beats offered then are dropped and flagged.
//
// Ports:
//   clk, rstn          clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready  upstream beat strobe / write bank can take a beat
//   shift_en, beat_idx one-hot bank shift enable and beat index, one-cycle pulse per accepted beat
//   out_valid/out_ready read bank holds a complete frame / downstream consumes it
//   rd_bank            bank steering the bit-reversal output mux
//   flush, clr_err     synchronous abort of all frames / clear of sticky overflow
//   overflow, frame_cnt sticky drop flag / count of delivered frames (wraps)

module reorder_frame_ctrl #(
    parameter int BEATS  = 16,
    parameter int FCNT_W = 16,
    localparam int IDX_W = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [1:0]        shift_en,
    output logic [IDX_W-1:0]  beat_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rd_bank,
    input  logic              flush,
    input  logic              clr_err,
    output logic              overflow,
    output logic [FCNT_W-1:0] frame_cnt
);

    // Per-bank lifecycle. FULL lasts exactly one cycle so the final shift
    // (registered one cycle after the last accept) has landed in the bank
    // before the frame is advertised as READY.
    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_FULL    = 2'd2,
        B_READY   = 2'd3
    } bank_st_t;

    bank_st_t         bank_st [0:1];
    logic             wr_bank;
    logic [IDX_W-1:0] cnt;

    logic wr_open;
    logic accept;
    logic last_beat;
    logic release_frame;

    // Write-side and read-side decode from registered bank state.
    // in_ready is gated with rstn so it reads 0 for the whole reset window.
    always_comb begin
        wr_open       = (bank_st[wr_bank] == B_EMPTY) || (bank_st[wr_bank] == B_FILLING);
        in_ready      = rstn & wr_open & ~flush;
        accept        = in_valid & in_ready;
        last_beat     = (cnt == IDX_W'(BEATS - 1));
        out_valid     = (bank_st[rd_bank] == B_READY);
        release_frame = out_valid & out_ready & ~flush;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            cnt        <= '0;
            shift_en   <= 2'b00;
            beat_idx   <= '0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else if (flush) begin
            // Abort everything in flight, including a shift for a beat that
            // would otherwise have been accepted this cycle. frame_cnt and
            // overflow survive; beats offered during flush are not flagged.
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            cnt        <= '0;
            shift_en   <= 2'b00;
            beat_idx   <= '0;
            if (clr_err) begin
                overflow <= 1'b0;
            end
        end else begin
            // One-cycle shift pulse towards the bank that took the beat.
            shift_en <= accept ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
            if (accept) begin
                beat_idx <= cnt;
            end

            // FULL banks become READY one cycle after the last beat's shift.
            for (int b = 0; b < 2; b++) begin
                if (bank_st[b] == B_FULL) begin
                    bank_st[b] <= B_READY;
                end
            end

            // Release and fill always touch different banks: the read bank
            // is READY while the write bank is EMPTY/FILLING, so both
            // updates can land in the same cycle without conflict.
            if (release_frame) begin
                bank_st[rd_bank] <= B_EMPTY;
                rd_bank          <= ~rd_bank;
                frame_cnt        <= frame_cnt + FCNT_W'(1);
            end

            if (accept) begin
                if (last_beat) begin
                    bank_st[wr_bank] <= B_FULL;
                    wr_bank          <= ~wr_bank;
                    cnt              <= '0;
                end else begin
                    bank_st[wr_bank] <= B_FILLING;
                    cnt              <= cnt + IDX_W'(1);
                end
            end

            // Setting wins over a simultaneous clear so no drop goes unseen.
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_frame_ctrl.sv
// Self-checking bench for reorder_frame_ctrl: directed scenarios with literal
// expectations plus a long randomized run against a queue-based frame model.

module tb_reorder_frame_ctrl;

    localparam int BEATS  = 16;
    localparam int FCNT_W = 16;
    localparam int IDX_W  = $clog2(BEATS);

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        shift_en;
    logic [IDX_W-1:0]  beat_idx;
    logic              out_valid;
    logic              out_ready;
    logic              rd_bank;
    logic              flush;
    logic              clr_err;
    logic              overflow;
    logic [FCNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    reorder_frame_ctrl #(.BEATS(BEATS), .FCNT_W(FCNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .beat_idx  (beat_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_bank   (rd_bank),
        .flush     (flush),
        .clr_err   (clr_err),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Frame-level model: each completed-but-undelivered frame is a queue
    // entry holding the cycle at which it becomes visible downstream. Two
    // banks means at most two such frames; the write side is open while
    // fewer than two are held.
    int                q[$];
    int                mcyc;
    int                mcnt;
    bit                mwr;
    bit                mrd;
    logic [1:0]        mshift;
    int                midx;
    bit                movf;
    bit [FCNT_W-1:0]   mfcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mcyc   = 0;
        mcnt   = 0;
        mwr    = 0;
        mrd    = 0;
        mshift = 2'b00;
        midx   = 0;
        movf   = 0;
        mfcnt  = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance
    // the model across the rising edge. Entered and left just after a negedge.
    task automatic step(input bit iv, input bit orr, input bit fl, input bit ce);
        bit rdy, vld, acc, rel;
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        clr_err   = ce;
        #1;
        rdy = (q.size() < 2) && !fl;
        vld = (q.size() > 0) && (q[0] <= mcyc);
        chk("in_ready",  in_ready,  rdy);
        chk("out_valid", out_valid, vld);
        chk("rd_bank",   rd_bank,   mrd);
        chk("shift_en",  shift_en,  mshift);
        if (mshift != 2'b00) chk("beat_idx", beat_idx, midx);
        chk("overflow",  overflow,  movf);
        chk("frame_cnt", frame_cnt, mfcnt);
        @(posedge clk);
        mcyc++;
        if (fl) begin
            q.delete();
            mcnt   = 0;
            mwr    = 0;
            mrd    = 0;
            mshift = 2'b00;
            if (ce) movf = 0;
        end else begin
            acc = iv && rdy;
            rel = vld && orr;
            mshift = acc ? (mwr ? 2'b10 : 2'b01) : 2'b00;
            if (acc) midx = mcnt;
            if (rel) begin
                void'(q.pop_front());
                mrd   = !mrd;
                mfcnt = mfcnt + 1'b1;
            end
            if (acc) begin
                mcnt++;
                if (mcnt == BEATS) begin
                    q.push_back(mcyc + 1);   // last beat at t -> visible at t+2
                    mcnt = 0;
                    mwr  = !mwr;
                end
            end
            if (iv && !rdy)  movf = 1;
            else if (ce)     movf = 0;
        end
        @(negedge clk);
    endtask

    // Assert reset between clock edges, check reset values immediately and
    // during the window, then release on a negedge.
    task automatic do_reset(input string tag);
        in_valid  = 0;
        out_ready = 0;
        flush     = 0;
        clr_err   = 0;
        rstn      = 0;
        #1;
        chk({tag, "_rst_in_ready"},  in_ready,  0);
        chk({tag, "_rst_shift_en"},  shift_en,  0);
        chk({tag, "_rst_beat_idx"},  beat_idx,  0);
        chk({tag, "_rst_out_valid"}, out_valid, 0);
        chk({tag, "_rst_rd_bank"},   rd_bank,   0);
        chk({tag, "_rst_overflow"},  overflow,  0);
        chk({tag, "_rst_frame_cnt"}, frame_cnt, 0);
        repeat (2) @(negedge clk);
        chk({tag, "_rst_hold_in_ready"}, in_ready, 0);
        rstn = 1;
        #1;
        chk({tag, "_rel_in_ready"}, in_ready, 1);
        model_reset();
    endtask

    initial begin
        rstn      = 0;
        in_valid  = 0;
        out_ready = 0;
        flush     = 0;
        clr_err   = 0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Single frame, downstream always ready.
        for (int k = 0; k < 20; k++) begin
            step(k < BEATS, 1, 0, 0);
            if (k == 0)  begin chk("p1_shift_t1", shift_en, 2'b01); chk("p1_idx_t1", beat_idx, 0); end
            if (k == 15) begin chk("p1_shift_t16", shift_en, 2'b01); chk("p1_idx_t16", beat_idx, 15); chk("p1_ov_t16", out_valid, 0); end
            if (k == 16) chk("p1_ov_t17", out_valid, 1);
            if (k == 17) begin chk("p1_ov_t18", out_valid, 0); chk("p1_fc_t18", frame_cnt, 1); end
        end

        // Ping-pong with stalled downstream, then a single release pulse.
        do_reset("pp");
        for (int k = 0; k < 48; k++) begin
            step(1, 0, 0, 0);
            if (k == 16) begin chk("pp_ov_t17", out_valid, 1); chk("pp_shift_t17", shift_en, 2'b10); end
            if (k == 31) chk("pp_shift_t32", shift_en, 2'b10);
            if (k == 32) chk("pp_rdy_t33", in_ready, 0);
            if (k == 34) chk("pp_ovf_t35", overflow, 1);
        end
        step(0, 1, 0, 0);
        chk("rel_rd_bank",   rd_bank,   1);
        chk("rel_frame_cnt", frame_cnt, 1);
        chk("rel_in_ready",  in_ready,  1);
        chk("rel_out_valid", out_valid, 1);

        // Overflow clear race: refill the freed bank, then offer a beat
        // while clr_err pulses.
        step(0, 0, 0, 1);
        chk("clr_ovf", overflow, 0);
        for (int k = 0; k < BEATS + 2; k++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("race_pre", overflow, 0);
        step(1, 0, 0, 1);
        chk("race_set_wins", overflow, 1);
        step(0, 0, 0, 1);
        chk("race_clear", overflow, 0);

        // Flush mid-fill, offering a beat during the flush itself.
        do_reset("fl");
        for (int k = 0; k < 7; k++) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_shift_en",  shift_en,  0);
        chk("fl_overflow",  overflow,  0);
        step(1, 1, 0, 0);
        chk("fl_idx_restart", beat_idx, 0);
        for (int k = 0; k < BEATS + 3; k++) step(k < BEATS - 1, 1, 0, 0);
        chk("fl_one_frame", frame_cnt, 1);

        // Asynchronous reset in the middle of a frame.
        do_reset("ar");
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0);
        #2;
        do_reset("ar_mid");
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
        chk("ar_no_frame", out_valid, 0);

        // Randomized traffic with periodic back-to-back streaming windows.
        for (int i = 0; i < 4000; i++) begin
            if ((i % 600) < 120) begin
                step(1, 1, 0, 0);
            end else begin
                step($urandom_range(99) < 80,
                     $urandom_range(99) < 45,
                     $urandom_range(199) < 3,
                     $urandom_range(99) < 5);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
